// File: rtl/anton_neopixel_receiver.sv
// anton_neopixel_receiver: WS2812/NeoPixel single-wire decoder sampled at 6.4 MHz (8 ticks per bit).
// Optional chained-pixel passthrough on neoDataOut: define ANTON_NEOPIXEL_RX_PASSTHROUGH_EN.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 63
`endif
`ifndef RESET_DELAY_DEFAULT
`define RESET_DELAY_DEFAULT 320
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module anton_neopixel_receiver #(
  parameter int BUFFER_END    = `BUFFER_END_DEFAULT,
  parameter int RESET_DELAY   = `RESET_DELAY_DEFAULT,
  parameter int BIT_THRESHOLD = 4,
  parameter int MIN_HIGH      = 1,
  parameter int MAX_HIGH      = 6,
  localparam int BUFFER_BITS  = `CLOG2(BUFFER_END + 1)
) (
  input  logic                   clk6_4mhz,
  input  logic                   reset,
  input  logic                   neoDataIn,
  input  logic                   errClear,
  output logic [7:0]             rxData,
  output logic                   rxValid,
  output logic                   rxFirst,
  output logic [BUFFER_BITS-1:0] rxIndex,
  output logic                   rxSync,
  output logic [BUFFER_BITS:0]   rxCount,
  output logic [2:0]             errFlags,
  output logic                   neoDataOut
);
  localparam int LOW_BITS  = $clog2(RESET_DELAY + 1);
  localparam int HIGH_BITS = $clog2(MAX_HIGH + 2);
  localparam logic [LOW_BITS-1:0]  LOW_LAST  = LOW_BITS'(RESET_DELAY - 1);
  localparam logic [HIGH_BITS-1:0] HIGH_LAST = HIGH_BITS'(MAX_HIGH - 1);
  localparam logic [HIGH_BITS-1:0] HIGH_MIN  = HIGH_BITS'(MIN_HIGH);
  localparam logic [HIGH_BITS-1:0] HIGH_MAX  = HIGH_BITS'(MAX_HIGH);
  localparam logic [HIGH_BITS-1:0] HIGH_ONE  = HIGH_BITS'(BIT_THRESHOLD);
  localparam logic [BUFFER_BITS:0] BYTE_LAST = (BUFFER_BITS + 1)'(BUFFER_END);

  localparam logic [1:0] ARMING = 2'd0;
  localparam logic [1:0] READY  = 2'd1;
  localparam logic [1:0] HIGH   = 2'd2;
  localparam logic [1:0] LOW    = 2'd3;

  logic                   syncMeta;
  logic                   sample;
  logic                   prevSample;
  logic [1:0]             state;
  logic [LOW_BITS-1:0]    lowCount;
  logic [HIGH_BITS-1:0]   highCount;
  logic [2:0]             bitCnt;
  logic [BUFFER_BITS:0]   byteCnt;
  logic [7:0]             shiftReg;

  logic                   rise;
  logic                   fall;
  logic                   widthOk;
  logic                   bitVal;
  logic                   overrun;
  logic                   pulseErr;
  logic                   frameEnd;
  logic [HIGH_BITS-1:0]   hiWidth;
  logic [7:0]             nextByte;

  // Two-flop synchronizer plus previous-sample register for edge detection.
  always_ff @(posedge clk6_4mhz or posedge reset) begin
    if (reset) begin
      syncMeta   <= 1'b0;
      sample     <= 1'b0;
      prevSample <= 1'b0;
    end else begin
      syncMeta   <= neoDataIn;
      sample     <= syncMeta;
      prevSample <= sample;
    end
  end

  // highCount excludes the rising sample itself, so the pulse width is highCount + 1.
  always_comb begin
    rise     = sample & ~prevSample;
    fall     = ~sample & prevSample;
    hiWidth  = highCount + HIGH_BITS'(1);
    widthOk  = (hiWidth >= HIGH_MIN) && (hiWidth <= HIGH_MAX);
    bitVal   = (hiWidth >= HIGH_ONE);
    nextByte = {shiftReg[6:0], bitVal};
    overrun  = (state == HIGH) && sample && (highCount >= HIGH_LAST);
    pulseErr = overrun || ((state == HIGH) && fall && !widthOk);
    frameEnd = (state == LOW) && !sample && (lowCount == LOW_LAST);
  end

  // Decode FSM, byte assembly and sticky error flags.
  always_ff @(posedge clk6_4mhz or posedge reset) begin
    if (reset) begin
      state     <= ARMING;
      lowCount  <= '0;
      highCount <= '0;
      bitCnt    <= 3'd0;
      byteCnt   <= '0;
      shiftReg  <= 8'h00;
      rxData    <= 8'h00;
      rxValid   <= 1'b0;
      rxFirst   <= 1'b0;
      rxIndex   <= '0;
      rxSync    <= 1'b0;
      rxCount   <= '0;
      errFlags  <= 3'b000;
    end else begin
      rxValid  <= 1'b0;
      rxSync   <= 1'b0;
      errFlags <= errClear ? 3'b000 : errFlags;
      case (state)
        ARMING: begin
          bitCnt <= 3'd0;
          if (sample) begin
            lowCount <= '0;
          end else if (lowCount == LOW_LAST) begin
            lowCount <= '0;
            state    <= READY;
          end else begin
            lowCount <= lowCount + LOW_BITS'(1);
          end
        end
        READY: begin
          if (rise) begin
            highCount <= '0;
            bitCnt    <= 3'd0;
            byteCnt   <= '0;
            state     <= HIGH;
          end else begin
            state <= READY;
          end
        end
        HIGH: begin
          if (pulseErr) begin
            errFlags[0] <= 1'b1;
            bitCnt      <= 3'd0;
            lowCount    <= '0;
            state       <= ARMING;
          end else if (fall) begin
            shiftReg <= nextByte;
            bitCnt   <= bitCnt + 3'd1;
            lowCount <= LOW_BITS'(1);
            state    <= LOW;
            if (bitCnt == 3'd7) begin
              if (byteCnt > BYTE_LAST) begin
                errFlags[2] <= 1'b1;
              end else begin
                rxValid <= 1'b1;
                rxData  <= nextByte;
                rxIndex <= byteCnt[BUFFER_BITS-1:0];
                rxFirst <= (byteCnt == '0);
                byteCnt <= byteCnt + (BUFFER_BITS + 1)'(1);
              end
            end
          end else begin
            highCount <= highCount + HIGH_BITS'(1);
          end
        end
        LOW: begin
          if (rise) begin
            highCount <= '0;
            state     <= HIGH;
          end else if (frameEnd) begin
            rxSync  <= 1'b1;
            rxCount <= byteCnt;
            if (bitCnt != 3'd0) begin
              errFlags[1] <= 1'b1;
            end else begin
              errFlags[1] <= errFlags[1] & ~errClear;
            end
            bitCnt <= 3'd0;
            state  <= READY;
          end else begin
            lowCount <= lowCount + LOW_BITS'(1);
          end
        end
        default: begin
          state <= ARMING;
        end
      endcase
    end
  end

`ifdef ANTON_NEOPIXEL_RX_PASSTHROUGH_EN
  logic ptActive;
  logic ptStart;

  // Forwarding begins on the rising edge that opens bit 0 of byte 3.
  always_comb begin
    ptStart = (state == LOW) && rise && (byteCnt >= (BUFFER_BITS + 1)'(3)) && (bitCnt == 3'd0);
  end

  // Chained-pixel forwarding of the synchronized line after the first three bytes.
  always_ff @(posedge clk6_4mhz or posedge reset) begin
    if (reset) begin
      ptActive   <= 1'b0;
      neoDataOut <= 1'b0;
    end else if (frameEnd || pulseErr || (state == ARMING)) begin
      ptActive   <= 1'b0;
      neoDataOut <= 1'b0;
    end else if (ptStart || ptActive) begin
      ptActive   <= 1'b1;
      neoDataOut <= sample;
    end else begin
      ptActive   <= 1'b0;
      neoDataOut <= 1'b0;
    end
  end
`else
  assign neoDataOut = 1'b0;
`endif

endmodule

// File: tb/tb_anton_neopixel_receiver.sv
// Self-checking bench for anton_neopixel_receiver: vector table, directed corner sequences, randomized frames.
module tb_anton_neopixel_receiver;
  localparam int BEND = 3;
  localparam int RDLY = 320;
  localparam int BB   = $clog2(BEND + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          neoDataIn;
  logic          errClear;
  logic [7:0]    rxData;
  logic          rxValid;
  logic          rxFirst;
  logic [BB-1:0] rxIndex;
  logic          rxSync;
  logic [BB:0]   rxCount;
  logic [2:0]    errFlags;
  logic          neoDataOut;

  anton_neopixel_receiver #(.BUFFER_END(BEND), .RESET_DELAY(RDLY)) dut (
    .clk6_4mhz (clk),
    .reset     (reset),
    .neoDataIn (neoDataIn),
    .errClear  (errClear),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .rxFirst   (rxFirst),
    .rxIndex   (rxIndex),
    .rxSync    (rxSync),
    .rxCount   (rxCount),
    .errFlags  (errFlags),
    .neoDataOut(neoDataOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [39:0] bytes;
    int          extra;
    logic [7:0]  extraVal;
    bit          clr;
    int          expCount;
    logic [2:0]  expErr;
  } vec_t;

  vec_t       tbl [0:4];
  logic [7:0] fb [0:4];
  logic [7:0] ev;
  logic [2:0] modelErr;
  int checks = 0;
  int errors = 0;
  int vBase, sBase, pBase, frameBitPos, ptExp;

  // Monitor: records strobes, frame ends and forwarded high ticks.
  logic [7:0] seenData [$];
  int         seenIdx [$];
  int         seenFirst [$];
  int         syncSeen = 0;
  int         lastCount = -1;
  int         ptSeen = 0;
  always @(negedge clk) begin
    if (rxValid) begin
      seenData.push_back(rxData);
      seenIdx.push_back(int'(rxIndex));
      seenFirst.push_back(int'(rxFirst));
    end
    if (rxSync) begin
      syncSeen  = syncSeen + 1;
      lastCount = int'(rxCount);
    end
    if (neoDataOut) ptSeen = ptSeen + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bit: nominal 5/3 or 2/6 ticks, or randomized legal widths.
  task automatic sendBit(input bit b, input bit jit);
    int hi, lo;
    if (jit) begin
      hi = b ? int'($urandom_range(6, 4)) : int'($urandom_range(3, 1));
      lo = int'($urandom_range(10, 2));
    end else begin
      hi = b ? 5 : 2;
      lo = b ? 3 : 6;
    end
    if (frameBitPos >= 24) ptExp += hi;
    frameBitPos++;
    neoDataIn = 1'b1;
    ticks(hi);
    neoDataIn = 1'b0;
    ticks(lo);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit jit);
    for (int k = 7; k >= 0; k--) sendBit(b[k], jit);
  endtask

  task automatic beginFrame();
    vBase       = seenData.size();
    sBase       = syncSeen;
    pBase       = ptSeen;
    frameBitPos = 0;
    ptExp       = 0;
  endtask

  task automatic pulseClear();
    errClear = 1'b1;
    ticks(1);
    errClear = 1'b0;
    ticks(1);
    modelErr = 3'b000;
  endtask

  task automatic checkFrame(input string tag, input int nBytes, input int expCount,
                            input logic [2:0] expErr, input bit expSync);
    int nValid, got;
    nValid = (nBytes > BEND + 1) ? BEND + 1 : nBytes;
    got    = seenData.size() - vBase;
    chk({tag, "/nvalid"}, got, nValid);
    for (int i = 0; i < nValid && i < got; i++) begin
      chk($sformatf("%s/data%0d", tag, i), int'(seenData[vBase + i]), int'(fb[i]));
      chk($sformatf("%s/idx%0d", tag, i), seenIdx[vBase + i], i);
      chk($sformatf("%s/first%0d", tag, i), seenFirst[vBase + i], (i == 0) ? 1 : 0);
    end
    chk({tag, "/sync"}, syncSeen - sBase, expSync ? 1 : 0);
    if (expSync) chk({tag, "/count"}, lastCount, expCount);
    chk({tag, "/err"}, int'(errFlags), int'(expErr));
`ifdef ANTON_NEOPIXEL_RX_PASSTHROUGH_EN
    chk({tag, "/passthru"}, ptSeen - pBase, ptExp);
`else
    chk({tag, "/passthru"}, ptSeen - pBase, 0);
`endif
  endtask

  initial begin
    int n, extra, expCount;
    tbl[0] = '{n:1, bytes:40'hA5_00_00_00_00, extra:0, extraVal:8'h00, clr:1'b0, expCount:1, expErr:3'b000};
    tbl[1] = '{n:3, bytes:40'h12_34_56_00_00, extra:0, extraVal:8'h00, clr:1'b0, expCount:3, expErr:3'b000};
    tbl[2] = '{n:3, bytes:40'h12_34_56_00_00, extra:0, extraVal:8'h00, clr:1'b0, expCount:3, expErr:3'b000};
    tbl[3] = '{n:1, bytes:40'hFF_00_00_00_00, extra:4, extraVal:8'h0F, clr:1'b0, expCount:1, expErr:3'b010};
    tbl[4] = '{n:5, bytes:40'h01_02_03_04_05, extra:0, extraVal:8'h00, clr:1'b1, expCount:4, expErr:3'b100};

    reset     = 1'b1;
    neoDataIn = 1'b0;
    errClear  = 1'b0;
    modelErr  = 3'b000;
    ticks(3);
    chk("reset/data", int'(rxData), 0);
    chk("reset/strobes", int'({rxValid, rxFirst, rxSync, neoDataOut}), 0);
    chk("reset/index_count", int'({rxIndex, rxCount}), 0);
    chk("reset/err", int'(errFlags), 0);
    reset = 1'b0;
    ticks(RDLY + 10);

    for (int t = 0; t < 5; t++) begin
      if (tbl[t].clr) pulseClear();
      beginFrame();
      for (int i = 0; i < tbl[t].n; i++) begin
        fb[i] = tbl[t].bytes[39 - 8 * i -: 8];
        sendByte(fb[i], 1'b0);
      end
      ev = tbl[t].extraVal;
      for (int k = tbl[t].extra - 1; k >= 0; k--) sendBit(ev[k], 1'b0);
      ticks(RDLY + 10);
      modelErr |= {tbl[t].n > BEND + 1, tbl[t].extra != 0, 1'b0};
      checkFrame($sformatf("vec%0d", t), tbl[t].n, tbl[t].expCount, tbl[t].expErr, 1'b1);
    end

    // Over-long high pulse mid-byte, then recovery and clear.
    pulseClear();
    beginFrame();
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    neoDataIn = 1'b1;
    ticks(8);
    neoDataIn = 1'b0;
    ticks(RDLY + 10);
    modelErr[0] = 1'b1;
    checkFrame("longpulse", 0, 0, 3'b001, 1'b0);
    beginFrame();
    fb[0] = 8'h3C;
    sendByte(fb[0], 1'b0);
    ticks(RDLY + 10);
    checkFrame("after_err", 1, 1, modelErr, 1'b1);
    pulseClear();
    chk("errclear", int'(errFlags), 0);

    // Reset mid-byte: nothing decodes until the line has re-armed.
    beginFrame();
    for (int k = 0; k < 4; k++) sendBit(k[0], 1'b0);
    reset = 1'b1;
    ticks(2);
    chk("midreset/outputs", int'({rxValid, rxSync, rxCount, errFlags}), 0);
    reset    = 1'b0;
    modelErr = 3'b000;
    ticks(20);
    beginFrame();
    sendByte(8'h55, 1'b0);
    ticks(RDLY + 10);
    checkFrame("rearm", 0, 0, 3'b000, 1'b0);
    beginFrame();
    fb[0] = 8'h81;
    sendByte(fb[0], 1'b0);
    ticks(RDLY + 10);
    checkFrame("rearmed", 1, 1, 3'b000, 1'b1);

    // Randomized frames with jittered legal timing against the frame-level model.
    for (int f = 0; f < 12; f++) begin
      n     = int'($urandom_range(5, 1));
      extra = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 1)) : 0;
      if ($urandom_range(1, 0) == 1) pulseClear();
      beginFrame();
      for (int i = 0; i < n; i++) begin
        fb[i] = 8'($urandom);
        sendByte(fb[i], 1'b1);
      end
      ev = 8'($urandom);
      for (int k = extra - 1; k >= 0; k--) sendBit(ev[k], 1'b1);
      ticks(RDLY + 10);
      modelErr |= {n > BEND + 1, extra != 0, 1'b0};
      expCount = (n > BEND + 1) ? BEND + 1 : n;
      checkFrame($sformatf("rand%0d", f), n, expCount, modelErr, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
